// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB (valid/tag/target) plus a table of 2-bit
// saturating direction counters, optionally gshare-indexed, with EX-stage
// mispredict detection and saturating statistics counters.
module branch_predictor #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned GSHARE   = 0,
  parameter logic [1:0]  INIT_CTR = 2'b01,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic [IDX_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic [IDX_W-1:0]  upd_ghr,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       lookup_cnt,
  output logic [31:0]       mispred_cnt
);

  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(4);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [IDX_W-1:0]   ghr_q;

  logic [IDX_W-1:0] l_idx, l_cidx, u_idx, u_cidx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit, u_hit;
  logic [1:0]       u_ctr, ctr_new;
  logic [IDX_W:0]   hist_shift;

  // Low PC bits are word-offset only and never index the tables.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], upd_pc[1:0], upd_ghr};

  // Lookup path: purely combinational from registered state, no update bypass.
  always_comb begin
    l_idx       = if_pc[IDX_W+1:2];
    l_tag       = if_pc[ADDR_W-1:IDX_W+2];
    l_cidx      = (GSHARE != 0) ? (l_idx ^ ghr_q) : l_idx;
    l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = l_hit && ctr_q[l_cidx][1];
    pred_target = pred_taken ? target_q[l_idx] : (if_pc + PC_INC);
    pred_ghr    = (GSHARE != 0) ? ghr_q : '0;
  end

  // Resolve path: mispredict detection and the next counter value for the update.
  always_comb begin
    u_idx      = upd_pc[IDX_W+1:2];
    u_tag      = upd_pc[ADDR_W-1:IDX_W+2];
    u_cidx     = (GSHARE != 0) ? (u_idx ^ upd_ghr) : u_idx;
    u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr      = ctr_q[u_cidx];
    hist_shift = {ghr_q, upd_taken};
    if (upd_taken) begin
      // A fresh allocation starts weakly taken regardless of the old counter.
      if (!u_hit)                ctr_new = 2'b10;
      else if (u_ctr == 2'b11)   ctr_new = u_ctr;
      else                       ctr_new = u_ctr + 2'd1;
    end else begin
      ctr_new = (u_ctr == 2'b00) ? u_ctr : (u_ctr - 2'd1);
    end
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : (upd_pc + PC_INC);
  end

  // Resettable state: valid bits, counters, history and statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= '0;
      ghr_q       <= '0;
      lookup_cnt  <= '0;
      mispred_cnt <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_q[i] <= INIT_CTR;
    end else begin
      if (upd_valid) begin
        ctr_q[u_cidx] <= ctr_new;
        ghr_q         <= hist_shift[IDX_W-1:0];
        if (upd_taken) valid_q[u_idx] <= 1'b1;
      end
      if (lookup_cnt != '1) lookup_cnt <= lookup_cnt + 32'd1;
      if (mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  // Tag/target payload: qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (reset && upd_valid && upd_taken) begin
      target_q[u_idx] <= upd_target;
      if (!u_hit) tag_q[u_idx] <= u_tag;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: one GSHARE=0 and one GSHARE=1 predictor share the same
// stimulus; each is compared against its own table-level reference model.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned IDX_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] if_pc;
  logic              upd_valid, upd_taken, upd_pred_taken;
  logic [ADDR_W-1:0] upd_pc, upd_target, upd_pred_target;
  logic [IDX_W-1:0]  upd_ghr;

  logic              pred_taken_g0, pred_taken_g1, mispredict_g0, mispredict_g1;
  logic [ADDR_W-1:0] pred_target_g0, pred_target_g1, redirect_pc_g0, redirect_pc_g1;
  logic [IDX_W-1:0]  pred_ghr_g0, pred_ghr_g1;
  logic [31:0]       lookup_cnt_g0, lookup_cnt_g1, mispred_cnt_g0, mispred_cnt_g1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .GSHARE(0), .INIT_CTR(2'b01)) u_g0 (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken_g0), .pred_target(pred_target_g0), .pred_ghr(pred_ghr_g0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(mispredict_g0), .redirect_pc(redirect_pc_g0),
    .lookup_cnt(lookup_cnt_g0), .mispred_cnt(mispred_cnt_g0)
  );

  branch_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .GSHARE(1), .INIT_CTR(2'b01)) u_g1 (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_taken(pred_taken_g1), .pred_target(pred_target_g1), .pred_ghr(pred_ghr_g1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target), .upd_ghr(upd_ghr),
    .mispredict(mispredict_g1), .redirect_pc(redirect_pc_g1),
    .lookup_cnt(lookup_cnt_g1), .mispred_cnt(mispred_cnt_g1)
  );

  // Reference model, one copy per instance (index 0: PC-indexed, 1: gshare).
  bit          m_valid  [2][ENTRIES];
  logic [31:0] m_tag    [2][ENTRIES];
  logic [31:0] m_target [2][ENTRIES];
  int          m_ctr    [2][ENTRIES];
  int          m_ghr    [2];
  longint      m_lookup, m_mispred;

  logic [31:0] pool [8];

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic int cidx_of(int g, int idx, int hist);
    return (g == 1) ? (idx ^ hist) : idx;
  endfunction

  function automatic bit m_hit(int g, logic [31:0] pc);
    return m_valid[g][idx_of(pc)] && (m_tag[g][idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(int g, logic [31:0] pc);
    return m_hit(g, pc) && (m_ctr[g][cidx_of(g, idx_of(pc), m_ghr[g])] >= 2);
  endfunction

  function automatic logic [31:0] m_ptarget(int g, logic [31:0] pc);
    return m_pred(g, pc) ? m_target[g][idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
  endfunction

  task automatic m_reset();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[g][i] = 1'b0;
        m_ctr[g][i]   = 1;
      end
      m_ghr[g] = 0;
    end
    m_lookup  = 0;
    m_mispred = 0;
  endtask

  task automatic m_edge();
    int idx, c;
    if (!reset) begin
      m_reset();
      return;
    end
    if (m_mis() && (m_mispred < 64'h0_FFFF_FFFF)) m_mispred++;
    if (m_lookup < 64'h0_FFFF_FFFF) m_lookup++;
    if (upd_valid) begin
      for (int g = 0; g < 2; g++) begin
        idx = idx_of(upd_pc);
        c   = cidx_of(g, idx, int'(upd_ghr));
        if (m_hit(g, upd_pc)) begin
          m_ctr[g][c] = upd_taken ? ((m_ctr[g][c] < 3) ? m_ctr[g][c] + 1 : 3)
                                  : ((m_ctr[g][c] > 0) ? m_ctr[g][c] - 1 : 0);
          if (upd_taken) m_target[g][idx] = upd_target;
        end else if (upd_taken) begin
          m_valid[g][idx]  = 1'b1;
          m_tag[g][idx]    = tag_of(upd_pc);
          m_target[g][idx] = upd_target;
          m_ctr[g][c]      = 2;
        end else begin
          m_ctr[g][c] = (m_ctr[g][c] > 0) ? m_ctr[g][c] - 1 : 0;
        end
        m_ghr[g] = ((m_ghr[g] << 1) | int'(upd_taken)) % ENTRIES;
      end
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive an update whose carried prediction is what model g predicted for pc.
  task automatic set_upd(int g, logic [31:0] pc, bit taken, logic [31:0] target);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = target;
    upd_pred_taken  = m_pred(g, pc);
    upd_pred_target = m_ptarget(g, pc);
    upd_ghr         = IDX_W'(m_ghr[1]);
  endtask

  task automatic no_upd();
    upd_valid       = 1'b0;
    upd_pc          = $urandom;
    upd_taken       = 1'($urandom);
    upd_target      = $urandom;
    upd_pred_taken  = 1'($urandom);
    upd_pred_target = $urandom;
    upd_ghr         = IDX_W'($urandom);
  endtask

  task automatic settle_check();
    #1;
    chk("pred_taken_g0",  64'(pred_taken_g0),  64'(m_pred(0, if_pc)));
    chk("pred_taken_g1",  64'(pred_taken_g1),  64'(m_pred(1, if_pc)));
    chk("pred_target_g0", 64'(pred_target_g0), 64'(m_ptarget(0, if_pc)));
    chk("pred_target_g1", 64'(pred_target_g1), 64'(m_ptarget(1, if_pc)));
    chk("pred_ghr_g0",    64'(pred_ghr_g0),    64'd0);
    chk("pred_ghr_g1",    64'(pred_ghr_g1),    64'(m_ghr[1]));
    chk("mispredict_g0",  64'(mispredict_g0),  64'(m_mis()));
    chk("mispredict_g1",  64'(mispredict_g1),  64'(m_mis()));
    if (upd_valid) begin
      chk("redirect_g0", 64'(redirect_pc_g0), 64'(upd_taken ? upd_target : upd_pc + 32'd4));
      chk("redirect_g1", 64'(redirect_pc_g1), 64'(upd_taken ? upd_target : upd_pc + 32'd4));
    end
    chk("lookup_cnt_g0",  64'(lookup_cnt_g0),  64'(m_lookup));
    chk("lookup_cnt_g1",  64'(lookup_cnt_g1),  64'(m_lookup));
    chk("mispred_cnt_g0", 64'(mispred_cnt_g0), 64'(m_mispred));
    chk("mispred_cnt_g1", 64'(mispred_cnt_g1), 64'(m_mispred));
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  initial begin
    pool[0] = 32'h0040_0020; pool[1] = 32'h0040_0060; pool[2] = 32'h0040_0024;
    pool[3] = 32'h0040_0100; pool[4] = 32'h0040_0200; pool[5] = 32'h0040_1020;
    pool[6] = 32'h0040_0044; pool[7] = 32'h0040_003c;

    // Reset held with a live allocating update: the update must be discarded.
    reset = 1'b0;
    if_pc = 32'h0040_0020;
    m_reset();
    set_upd(0, 32'h0040_0020, 1'b1, 32'h0040_0100);
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    settle_check();
    chk("rst_pred_taken", 64'(pred_taken_g0), 64'd0);
    tick();

    reset = 1'b1;
    no_upd();
    if_pc = 32'h0040_0010;
    settle_check();
    chk("r038_taken",  64'(pred_taken_g0),  64'd0);
    chk("r038_target", 64'(pred_target_g0), 64'h0040_0014);
    chk("r038_lookup", 64'(lookup_cnt_g0),  64'd0);
    tick();
    settle_check();
    chk("r038_lookup1", 64'(lookup_cnt_g0), 64'd1);
    tick();

    // Taken allocation with a same-cycle lookup of the same PC.
    if_pc = 32'h0040_0020;
    set_upd(0, 32'h0040_0020, 1'b1, 32'h0040_0100);
    settle_check();
    chk("r039_mispredict", 64'(mispredict_g0),  64'd1);
    chk("r039_redirect",   64'(redirect_pc_g0), 64'h0040_0100);
    chk("r042_same_cycle", 64'(pred_taken_g0),  64'd0);
    tick();
    no_upd();
    settle_check();
    chk("r039_hit_taken",  64'(pred_taken_g0),  64'd1);
    chk("r039_hit_target", 64'(pred_target_g0), 64'h0040_0100);
    tick();

    // Saturate, then decay with two not-taken resolutions.
    for (int i = 0; i < 3; i++) begin
      set_upd(0, 32'h0040_0020, 1'b1, 32'h0040_0100);
      settle_check();
      tick();
    end
    set_upd(0, 32'h0040_0020, 1'b0, 32'h0040_0100);
    settle_check();
    tick();
    no_upd();
    settle_check();
    chk("r040_still_taken", 64'(pred_taken_g0), 64'd1);
    tick();
    set_upd(0, 32'h0040_0020, 1'b0, 32'h0040_0100);
    settle_check();
    chk("r040_mispredict", 64'(mispredict_g0), 64'd1);
    tick();
    no_upd();
    settle_check();
    chk("r040_not_taken", 64'(pred_taken_g0), 64'd0);
    tick();

    // Aliasing: 0x60 evicts 0x20 at index 8.
    set_upd(0, 32'h0040_0060, 1'b1, 32'h0040_0600);
    settle_check();
    tick();
    no_upd();
    if_pc = 32'h0040_0020;
    settle_check();
    chk("r041_alias_miss", 64'(pred_taken_g0), 64'd0);
    tick();
    if_pc = 32'h0040_0060;
    settle_check();
    chk("r041_new_taken",  64'(pred_taken_g0),  64'd1);
    chk("r041_new_target", 64'(pred_target_g0), 64'h0040_0600);
    tick();

    // Randomised traffic over a small aliasing PC pool.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      if_pc = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) != 0) begin
        set_upd(int'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 1'($urandom),
                pool[$urandom_range(0, 7)]);
        if ($urandom_range(0, 7) == 0) upd_pred_taken = ~upd_pred_taken;
      end else begin
        no_upd();
      end
      settle_check();
      tick();
    end

    // Gshare learns an alternating branch; then reset mid-sequence.
    reset = 1'b0;
    no_upd();
    settle_check();
    tick();
    reset = 1'b1;
    if_pc = 32'h0040_0200;
    for (int n = 0; n < 50; n++) begin
      set_upd(1, 32'h0040_0200, 1'((n + 1) % 2), 32'h0040_0300);
      settle_check();
      if (n >= 40) chk("r043_no_mispredict", 64'(mispredict_g1), 64'd0);
      tick();
    end
    reset = 1'b0;
    set_upd(1, 32'h0040_0200, 1'b1, 32'h0040_0300);
    settle_check();
    tick();
    reset = 1'b1;
    no_upd();
    settle_check();
    chk("r043_cnt_cleared", 64'(mispred_cnt_g1), 64'd0);
    chk("r043_lookup_miss", 64'(pred_taken_g1),  64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
